// File: rtl/uart_boot_loader_pkg.sv
// Shared types and protocol constants for the UART boot loader.
// Frame bytes, reply codes and FSM state encoding.
package uart_boot_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_WRITE,
      S_REPLY,
      S_RUN
   } state_t;

   localparam logic [7:0] CMD_WRITE = 8'h01;
   localparam logic [7:0] CMD_BOOT  = 8'h02;
   localparam logic [7:0] ACK       = 8'h06;
   localparam logic [7:0] NAK       = 8'h15;

endpackage

// File: rtl/uart_boot_loader.sv
// Byte-stream loader: fills instruction memory from write frames,
// acknowledges each frame, and releases the core on a boot frame.
module uart_boot_loader
   import uart_boot_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 14,
   parameter int TIMEOUT    = 1048575
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_canGet,
   input  logic [7:0]            in_getData,
   output logic                  in_get,
   output logic                  out_canGet,
   output logic [7:0]            out_getData,
   input  logic                  out_get,
   output logic                  imem_write,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_data,
   output logic                  cpu_run,
   output logic [7:0]            err_count
);

   localparam int TW = $clog2(TIMEOUT + 1);

   state_t        state_q;
   state_t        state_n;
   logic [1:0]    byte_cnt_q;
   logic [31:0]   addr_q;
   logic [31:0]   data_q;
   logic [TW-1:0] idle_q;
   logic          in_frame;
   logic          idle_hit;
   logic          addr_ok;
   logic          last_data;
   logic          err_inc;

   assign in_frame  = (state_q == S_ADDR) || (state_q == S_DATA);
   assign in_get    = in_canGet &&
                      ((state_q == S_IDLE) || in_frame);
   assign idle_hit  = in_frame && !in_get &&
                      (idle_q == TW'(TIMEOUT - 1));
   assign last_data = (state_q == S_DATA) && in_get &&
                      (byte_cnt_q == 2'd3);
   // Word aligned and inside the addressable memory window.
   assign addr_ok   = (addr_q[1:0] == 2'b00) &&
                      ((addr_q >> (ADDR_WIDTH + 2)) == 32'd0);

   always_comb begin
      state_n = state_q;
      err_inc = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (in_canGet) begin
               if (in_getData == CMD_WRITE)
                  state_n = S_ADDR;
               else if (in_getData == CMD_BOOT)
                  state_n = S_RUN;
               else
                  err_inc = 1'b1;
            end
         end
         S_ADDR: begin
            if (in_canGet) begin
               if (byte_cnt_q == 2'd3)
                  state_n = S_DATA;
            end else if (idle_hit) begin
               state_n = S_IDLE;
               err_inc = 1'b1;
            end
         end
         S_DATA: begin
            if (in_canGet) begin
               if (byte_cnt_q == 2'd3)
                  state_n = S_WRITE;
            end else if (idle_hit) begin
               state_n = S_IDLE;
               err_inc = 1'b1;
            end
         end
         S_WRITE: begin
            state_n = S_REPLY;
            err_inc = !addr_ok;
         end
         S_REPLY: begin
            if (out_get)
               state_n = S_IDLE;
         end
         S_RUN: state_n = S_RUN;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         byte_cnt_q  <= 2'd0;
         addr_q      <= 32'd0;
         data_q      <= 32'd0;
         idle_q      <= '0;
         imem_write  <= 1'b0;
         imem_addr   <= '0;
         imem_data   <= 32'd0;
         out_canGet  <= 1'b0;
         out_getData <= 8'd0;
         cpu_run     <= 1'b0;
         err_count   <= 8'd0;
      end else begin
         state_q <= state_n;

         if (in_get || idle_hit || !in_frame)
            idle_q <= '0;
         else
            idle_q <= idle_q + TW'(1);

         if (!in_frame || idle_hit)
            byte_cnt_q <= 2'd0;
         else if (in_get)
            byte_cnt_q <= byte_cnt_q + 2'd1;

         // Little-endian: shift new bytes in from the top.
         if (in_get && state_q == S_ADDR)
            addr_q <= {in_getData, addr_q[31:8]};
         if (in_get && state_q == S_DATA)
            data_q <= {in_getData, data_q[31:8]};

         imem_write <= last_data && addr_ok;
         if (last_data && addr_ok) begin
            imem_addr <= addr_q[ADDR_WIDTH+1:2];
            imem_data <= {in_getData, data_q[31:8]};
         end

         out_canGet <= (state_n == S_REPLY);
         if (state_q == S_WRITE)
            out_getData <= addr_ok ? ACK : NAK;

         cpu_run <= cpu_run || (state_n == S_RUN);

         if (err_inc && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader with a queue-based
// scoreboard checking memory writes and reply bytes.
module tb_uart_boot_loader;

   localparam int AW = 14;
   localparam int TO = 40;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_canGet = 1'b0;
   logic [7:0]    in_getData = 8'h00;
   logic          in_get;
   logic          out_canGet;
   logic [7:0]    out_getData;
   logic          out_get = 1'b0;
   logic          imem_write;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_data;
   logic          cpu_run;
   logic [7:0]    err_count;

   int passed = 0;
   int total  = 0;

   logic [AW-1:0] exp_wa[$];
   logic [31:0]   exp_wd[$];
   logic [7:0]    exp_rp[$];

   uart_boot_loader #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .clock      (clk),
      .reset      (rst_n),
      .in_canGet  (in_canGet),
      .in_getData (in_getData),
      .in_get     (in_get),
      .out_canGet (out_canGet),
      .out_getData(out_getData),
      .out_get    (out_get),
      .imem_write (imem_write),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .cpu_run    (cpu_run),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Scoreboard monitor: compares whatever the DUT presents.
   always @(negedge clk) begin
      if (rst_n && imem_write) begin
         if (exp_wa.size() == 0) begin
            total++;
            $display("FAIL unexpected_write: addr %0h data %0h expected none",
                     imem_addr, imem_data);
         end else begin
            chk("write_addr", 32'(imem_addr), 32'(exp_wa.pop_front()));
            chk("write_data", imem_data, exp_wd.pop_front());
         end
      end
      if (rst_n && out_canGet && out_get) begin
         if (exp_rp.size() == 0) begin
            total++;
            $display("FAIL unexpected_reply: got %0h expected none",
                     out_getData);
         end else begin
            chk("reply", 32'(out_getData), 32'(exp_rp.pop_front()));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_canGet  = 1'b1;
      in_getData = b;
      #1;
      while (!in_get && n < 200) begin
         @(posedge clk); #2;
         n++;
      end
      if (!in_get) begin
         total++;
         $display("FAIL send_timeout: byte %0h not consumed, expected consumed", b);
      end
      @(posedge clk); #1;
      in_canGet = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] a, input logic [31:0] d);
      send_byte(8'h01);
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
      for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
   endtask

   task automatic take_reply();
      int n = 0;
      while (!out_canGet && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!out_canGet) begin
         total++;
         $display("FAIL reply_timeout: out_canGet 0 expected 1");
      end
      out_get = 1'b1;
      @(posedge clk); #1;
      out_get = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int bad;
      cycles(3);
      chk("rst_imem_write", 32'(imem_write), 32'd0);
      chk("rst_out_canGet", 32'(out_canGet), 32'd0);
      chk("rst_cpu_run", 32'(cpu_run), 32'd0);
      chk("rst_err", 32'(err_count), 32'd0);
      chk("rst_imem_addr", 32'(imem_addr), 32'd0);
      chk("rst_imem_data", imem_data, 32'd0);
      rst_n = 1'b1;
      cycles(2);

      // Basic write to address 0.
      exp_wa.push_back(14'h0000); exp_wd.push_back(32'hDEADBEEF);
      exp_rp.push_back(8'h06);
      send_frame(32'h0000_0000, 32'hDEADBEEF);
      take_reply();

      // Misaligned address.
      exp_rp.push_back(8'h15);
      send_frame(32'h0000_0006, 32'h1111_2222);
      take_reply();
      chk("err_misaligned", 32'(err_count), 32'd1);

      // Highest valid word.
      exp_wa.push_back(14'h3FFF); exp_wd.push_back(32'h12345678);
      exp_rp.push_back(8'h06);
      send_frame(32'h0000_FFFC, 32'h12345678);
      take_reply();

      // First out-of-range word.
      exp_rp.push_back(8'h15);
      send_frame(32'h0001_0000, 32'h3333_4444);
      take_reply();
      chk("err_range", 32'(err_count), 32'd2);

      send_byte(8'h55);
      cycles(1);
      chk("err_badcmd", 32'(err_count), 32'd3);

      // Reply held off with input pending.
      exp_wa.push_back(14'h0001); exp_wd.push_back(32'hCAFEF00D);
      exp_rp.push_back(8'h06);
      send_frame(32'h0000_0004, 32'hCAFEF00D);
      cycles(2);
      chk("hold_canGet", 32'(out_canGet), 32'd1);
      in_canGet = 1'b1; in_getData = 8'h01;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_get !== 1'b0 || out_getData !== 8'h06 ||
             out_canGet !== 1'b1) bad++;
      end
      #1;
      chk("hold_stable", 32'(bad), 32'd0);
      in_canGet = 1'b0;
      @(posedge clk); #1;
      take_reply();

      // Partial frame then idle timeout.
      send_byte(8'h01); send_byte(8'h10); send_byte(8'h00);
      cycles(TO - 2);
      chk("pre_timeout_err", 32'(err_count), 32'd3);
      cycles(4);
      chk("timeout_err", 32'(err_count), 32'd4);
      exp_wa.push_back(14'h0002); exp_wd.push_back(32'hA5A55A5A);
      exp_rp.push_back(8'h06);
      send_frame(32'h0000_0008, 32'hA5A55A5A);
      take_reply();

      // Reset after the sixth byte.
      send_byte(8'h01);
      for (int i = 0; i < 4; i++) send_byte(8'h00);
      send_byte(8'h77);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_write", 32'(imem_write), 32'd0);
      chk("mid_rst_canGet", 32'(out_canGet), 32'd0);
      chk("mid_rst_err", 32'(err_count), 32'd0);
      chk("mid_rst_addr", 32'(imem_addr), 32'd0);
      chk("mid_rst_data", imem_data, 32'd0);
      cycles(2);
      rst_n = 1'b1;
      cycles(10);
      chk("post_rst_canGet", 32'(out_canGet), 32'd0);

      // Error counter saturation.
      for (int i = 0; i < 260; i++) send_byte(8'hFF);
      cycles(1);
      chk("err_saturate", 32'(err_count), 32'd255);

      // Boot.
      send_byte(8'h02);
      chk("boot_run", 32'(cpu_run), 32'd1);
      in_canGet = 1'b1; in_getData = 8'h01;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (in_get !== 1'b0 || out_canGet !== 1'b0 ||
             cpu_run !== 1'b1 || imem_write !== 1'b0) bad++;
      end
      #1;
      chk("run_locked", 32'(bad), 32'd0);
      in_canGet = 1'b0;

      cycles(2);
      chk("left_writes", 32'(exp_wa.size()), 32'd0);
      chk("left_replies", 32'(exp_rp.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/uart_boot_loader.md
UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 14, is the instruction-memory word-address width.
REQ-002 Parameter TIMEOUT, default 1048575, is the maximum idle cycles between bytes of one frame.
REQ-003 clock  input  1  the only clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_canGet  input  1  upstream byte stream (JTAG UART output) has a byte.
REQ-006 in_getData  input  8  upstream byte, valid when in_canGet=1.
REQ-007 in_get  output  1  consume the upstream byte this cycle.
REQ-008 out_canGet  output  1  reply byte available to the JTAG UART input side.
REQ-009 out_getData  output  8  reply byte.
REQ-010 out_get  input  1  consumer takes the reply byte this cycle.
REQ-011 imem_write  output  1  one-cycle instruction-memory write strobe.
REQ-012 imem_addr  output  ADDR_WIDTH  word address for imem_write.
REQ-013 imem_data  output  32  write data for imem_write.
REQ-014 cpu_run  output  1  releases the Pebbles core; sticky until reset.
REQ-015 err_count  output  8  saturating count of protocol errors.

Function
REQ-016 Frame formats: write = 0x01, 4 address bytes, 4 data bytes; boot = 0x02; both multi-byte fields little-endian.
REQ-017 States: IDLE, ADDR, DATA, WRITE, REPLY, RUN.
REQ-018 in_get = in_canGet AND state in {IDLE, ADDR, DATA}, combinational; a byte is consumed exactly in that cycle.
REQ-019 IDLE: 0x01 -> ADDR; 0x02 -> RUN; any other byte -> stay IDLE, err_count+1.
REQ-020 ADDR and DATA each consume 4 bytes, tracked by a 2-bit byte counter; the 4th byte moves ADDR->DATA and DATA->WRITE.
REQ-021 WRITE lasts one cycle and always exits to REPLY.
REQ-022 WRITE with address[1:0]=0 and address[31:ADDR_WIDTH+2]=0: imem_write=1, imem_addr=address[ADDR_WIDTH+1:2], imem_data=data, reply 0x06.
REQ-023 WRITE with any other address: imem_write stays 0, reply 0x15, err_count+1.
REQ-024 REPLY: out_canGet=1 and out_getData holds the reply byte stable; out_get -> IDLE; no input is consumed while in REPLY.
REQ-025 out_get while out_canGet=0 is ignored.
REQ-026 RUN: cpu_run=1, in_get=0, out_canGet=0; exited only by reset.
REQ-027 Timeout: in ADDR or DATA, an idle counter resets on each consumed byte; reaching TIMEOUT -> IDLE, frame discarded, err_count+1.
REQ-028 err_count saturates at 255; an increment at 255 leaves it at 255.
REQ-029 Outputs are registered except in_get; imem_write is high only in the WRITE cycle.

Reset
REQ-030 Reset asserted, at any time including mid-frame or mid-reply: state=IDLE, all counters 0, cpu_run=0, imem_write=0, out_canGet=0, err_count=0, imem_addr=0, imem_data=0.
REQ-031 A partial frame is discarded by reset; no write or reply follows it.

Structure
REQ-032 A shared package holds the state enum, CMD_WRITE=0x01, CMD_BOOT=0x02, ACK=0x06 and NAK=0x15.
REQ-033 Implementation is a single module with no sub-modules.

Verification
REQ-034 Send 01 00 00 00 00 EF BE AD DE -> one imem_write, addr 0, data 0xDEADBEEF, then reply 0x06.
REQ-035 Send 01 06 00 00 00 plus 4 data bytes -> no imem_write, reply 0x15, err_count=1.
REQ-036 Hold out_get=0 for 20 cycles in REPLY with in_canGet=1 -> in_get stays 0 and out_getData stays stable; the next frame proceeds after out_get.
REQ-037 Send 01 10 00, then idle TIMEOUT cycles -> returns to IDLE, err_count=1; a following full frame writes correctly.
REQ-038 Send 02 -> cpu_run=1 from the next cycle; further bytes are not consumed.
REQ-039 Assert reset after the 6th byte of a write frame -> all outputs at reset values, no imem_write.
